// File: rtl/vcache_dma_arbiter.sv
// Round-robin arbiter that shares one DRAM DMA channel among several vcache DMA ports.
// One transaction (packet, then one block of fill or evict data) is in flight at a time.
module vcache_dma_arbiter #(
    parameter  int num_caches_p          = 4,
    parameter  int addr_width_p          = 32,
    parameter  int data_width_p          = 32,
    parameter  int block_size_in_words_p = 8,
    localparam int dma_pkt_width_lp      = addr_width_p + 1,
    localparam int lg_caches_lp          = $clog2(num_caches_p)
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,

    input  logic [num_caches_p*dma_pkt_width_lp-1:0] cache_dma_pkt_i,
    input  logic [num_caches_p-1:0]                cache_dma_pkt_v_i,
    output logic [num_caches_p-1:0]                cache_dma_pkt_yumi_o,

    output logic [data_width_p-1:0]                cache_dma_data_o,
    output logic [num_caches_p-1:0]                cache_dma_data_v_o,
    input  logic [num_caches_p-1:0]                cache_dma_data_ready_i,

    input  logic [num_caches_p*data_width_p-1:0]   cache_dma_data_i,
    input  logic [num_caches_p-1:0]                cache_dma_data_v_i,
    output logic [num_caches_p-1:0]                cache_dma_data_yumi_o,

    output logic [dma_pkt_width_lp-1:0]            dma_pkt_o,
    output logic                                   dma_pkt_v_o,
    input  logic                                   dma_pkt_yumi_i,

    input  logic [data_width_p-1:0]                dma_data_i,
    input  logic                                   dma_data_v_i,
    output logic                                   dma_data_ready_o,

    output logic [data_width_p-1:0]                dma_data_o,
    output logic                                   dma_data_v_o,
    input  logic                                   dma_data_yumi_i,

    output logic [lg_caches_lp-1:0]                grant_id_o,
    output logic                                   busy_o
);

    localparam int cnt_width_lp = $clog2(block_size_in_words_p) + 1;
    localparam logic [cnt_width_lp-1:0] last_cnt_lp = cnt_width_lp'(block_size_in_words_p - 1);
    localparam logic [lg_caches_lp-1:0] last_cache_lp = lg_caches_lp'(num_caches_p - 1);

    typedef enum logic [1:0] {IDLE, SEND, RD, WR} state_e;

    state_e                  state_q, state_d;
    logic [lg_caches_lp-1:0] rr_ptr_q, rr_ptr_d;
    logic [lg_caches_lp-1:0] sel_q, sel_d;
    logic [cnt_width_lp-1:0] word_cnt_q, word_cnt_d;

    logic [dma_pkt_width_lp-1:0] pkt_sel;
    logic [data_width_p-1:0]     evict_sel;
    logic                        rd_xfer;
    logic                        wr_xfer;
    logic                        found;
    logic [lg_caches_lp-1:0]     pick;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            sel_q      <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            sel_q      <= sel_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    // First requester at or after rr_ptr, wrapping around the port list.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < num_caches_p; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= num_caches_p) begin
                idx = idx - num_caches_p;
            end
            if (!found && cache_dma_pkt_v_i[idx]) begin
                found = 1'b1;
                pick  = lg_caches_lp'(idx);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        sel_d      = sel_q;
        word_cnt_d = word_cnt_q;

        cache_dma_pkt_yumi_o  = '0;
        cache_dma_data_o      = '0;
        cache_dma_data_v_o    = '0;
        cache_dma_data_yumi_o = '0;
        dma_pkt_o             = '0;
        dma_pkt_v_o           = 1'b0;
        dma_data_ready_o      = 1'b0;
        dma_data_o            = '0;
        dma_data_v_o          = 1'b0;

        pkt_sel   = cache_dma_pkt_i[sel_q*dma_pkt_width_lp +: dma_pkt_width_lp];
        evict_sel = cache_dma_data_i[sel_q*data_width_p +: data_width_p];
        rd_xfer   = dma_data_v_i & cache_dma_data_ready_i[sel_q];
        wr_xfer   = dma_data_yumi_i & cache_dma_data_v_i[sel_q];

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    sel_d   = pick;
                    state_d = SEND;
                end
            end
            SEND: begin
                dma_pkt_o   = pkt_sel;
                dma_pkt_v_o = 1'b1;
                if (dma_pkt_yumi_i) begin
                    cache_dma_pkt_yumi_o[sel_q] = 1'b1;
                    rr_ptr_d   = (sel_q == last_cache_lp) ? '0 : sel_q + lg_caches_lp'(1);
                    word_cnt_d = '0;
                    state_d    = pkt_sel[dma_pkt_width_lp-1] ? WR : RD;
                end
            end
            RD: begin
                cache_dma_data_o          = dma_data_i;
                cache_dma_data_v_o[sel_q] = dma_data_v_i;
                dma_data_ready_o          = cache_dma_data_ready_i[sel_q];
                if (rd_xfer) begin
                    if (word_cnt_q == last_cnt_lp) begin
                        state_d = IDLE;
                    end else begin
                        word_cnt_d = word_cnt_q + cnt_width_lp'(1);
                    end
                end
            end
            WR: begin
                dma_data_o                   = evict_sel;
                dma_data_v_o                 = cache_dma_data_v_i[sel_q];
                cache_dma_data_yumi_o[sel_q] = wr_xfer;
                if (wr_xfer) begin
                    if (word_cnt_q == last_cnt_lp) begin
                        state_d = IDLE;
                    end else begin
                        word_cnt_d = word_cnt_q + cnt_width_lp'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Reset silences every handshake immediately, before the flops clear.
        if (!reset_n_i) begin
            cache_dma_pkt_yumi_o  = '0;
            cache_dma_data_o      = '0;
            cache_dma_data_v_o    = '0;
            cache_dma_data_yumi_o = '0;
            dma_pkt_o             = '0;
            dma_pkt_v_o           = 1'b0;
            dma_data_ready_o      = 1'b0;
            dma_data_o            = '0;
            dma_data_v_o          = 1'b0;
        end
    end

    assign grant_id_o = reset_n_i ? sel_q : '0;
    assign busy_o     = reset_n_i && (state_q != IDLE);

endmodule

// File: tb/tb_vcache_dma_arbiter.sv
// Directed bench for vcache_dma_arbiter: read, write, backpressure, packet stall,
// reset mid-transfer and round-robin fairness, with hand-computed expectations.
module tb_vcache_dma_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int B  = 8;
    localparam int PW = AW + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n;
    logic [N*PW-1:0]   cache_dma_pkt_i;
    logic [N-1:0]      cache_dma_pkt_v_i;
    logic [N-1:0]      cache_dma_pkt_yumi_o;
    logic [DW-1:0]     cache_dma_data_o;
    logic [N-1:0]      cache_dma_data_v_o;
    logic [N-1:0]      cache_dma_data_ready_i;
    logic [N*DW-1:0]   cache_dma_data_i;
    logic [N-1:0]      cache_dma_data_v_i;
    logic [N-1:0]      cache_dma_data_yumi_o;
    logic [PW-1:0]     dma_pkt_o;
    logic              dma_pkt_v_o;
    logic              dma_pkt_yumi_i;
    logic [DW-1:0]     dma_data_i;
    logic              dma_data_v_i;
    logic              dma_data_ready_o;
    logic [DW-1:0]     dma_data_o;
    logic              dma_data_v_o;
    logic              dma_data_yumi_i;
    logic [1:0]        grant_id_o;
    logic              busy_o;

    logic [PW-1:0] pkt_a [N];
    logic [DW-1:0] evict_a [N];

    int compared   = 0;
    int mismatched = 0;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign cache_dma_pkt_i[g*PW +: PW]  = pkt_a[g];
        assign cache_dma_data_i[g*DW +: DW] = evict_a[g];
    end

    vcache_dma_arbiter #(
        .num_caches_p(N), .addr_width_p(AW), .data_width_p(DW), .block_size_in_words_p(B)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .cache_dma_pkt_i(cache_dma_pkt_i), .cache_dma_pkt_v_i(cache_dma_pkt_v_i),
        .cache_dma_pkt_yumi_o(cache_dma_pkt_yumi_o),
        .cache_dma_data_o(cache_dma_data_o), .cache_dma_data_v_o(cache_dma_data_v_o),
        .cache_dma_data_ready_i(cache_dma_data_ready_i),
        .cache_dma_data_i(cache_dma_data_i), .cache_dma_data_v_i(cache_dma_data_v_i),
        .cache_dma_data_yumi_o(cache_dma_data_yumi_o),
        .dma_pkt_o(dma_pkt_o), .dma_pkt_v_o(dma_pkt_v_o), .dma_pkt_yumi_i(dma_pkt_yumi_i),
        .dma_data_i(dma_data_i), .dma_data_v_i(dma_data_v_i), .dma_data_ready_o(dma_data_ready_o),
        .dma_data_o(dma_data_o), .dma_data_v_o(dma_data_v_o), .dma_data_yumi_i(dma_data_yumi_i),
        .grant_id_o(grant_id_o), .busy_o(busy_o)
    );

    function automatic logic [N-1:0] onehot(input int id);
        onehot = 4'b0001 << id;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_quiet(input string tag);
        check_output({tag, "_pkt_yumi"},   64'(cache_dma_pkt_yumi_o),  64'h0);
        check_output({tag, "_cdata_v"},    64'(cache_dma_data_v_o),    64'h0);
        check_output({tag, "_cdata"},      64'(cache_dma_data_o),      64'h0);
        check_output({tag, "_cevict_yumi"},64'(cache_dma_data_yumi_o), 64'h0);
        check_output({tag, "_pkt_v"},      64'(dma_pkt_v_o),           64'h0);
        check_output({tag, "_pkt"},        64'(dma_pkt_o),             64'h0);
        check_output({tag, "_rd_ready"},   64'(dma_data_ready_o),      64'h0);
        check_output({tag, "_wr_v"},       64'(dma_data_v_o),          64'h0);
        check_output({tag, "_wr_data"},    64'(dma_data_o),            64'h0);
        check_output({tag, "_grant"},      64'(grant_id_o),            64'h0);
        check_output({tag, "_busy"},       64'(busy_o),                64'h0);
    endtask

    // Starts in IDLE with the request already raised; runs SEND and the read block.
    task automatic apply_stimulus(input int id, input logic [AW-1:0] addr, input logic [DW-1:0] base,
                                  input int send_stall, input int late_id, input int stall_at,
                                  input int abort_after, input bit drop_req);
        #1;
        check_output("idle_busy",  64'(busy_o),      64'h0);
        check_output("idle_pkt_v", 64'(dma_pkt_v_o), 64'h0);
        tick();
        if (late_id >= 0) cache_dma_pkt_v_i[late_id] = 1'b1;
        for (int s = 0; s < send_stall; s++) begin
            #1;
            check_output("stall_pkt",   64'(dma_pkt_o),  64'({1'b0, addr}));
            check_output("stall_grant", 64'(grant_id_o), 64'(id));
            check_output("stall_yumi",  64'(cache_dma_pkt_yumi_o), 64'h0);
            tick();
        end
        dma_pkt_yumi_i = 1'b1;
        #1;
        check_output("send_busy",  64'(busy_o),      64'h1);
        check_output("send_grant", 64'(grant_id_o),  64'(id));
        check_output("send_pkt_v", 64'(dma_pkt_v_o), 64'h1);
        check_output("send_pkt",   64'(dma_pkt_o),   64'({1'b0, addr}));
        check_output("send_yumi",  64'(cache_dma_pkt_yumi_o), 64'(onehot(id)));
        tick();
        dma_pkt_yumi_i = 1'b0;
        if (drop_req) cache_dma_pkt_v_i[id] = 1'b0;
        for (int k = 0; k < B; k++) begin
            if (k == abort_after) return;
            if (k == stall_at) begin
                for (int s = 0; s < 5; s++) begin
                    cache_dma_data_ready_i = '0;
                    dma_data_v_i = 1'b1;
                    dma_data_i   = base + DW'(k);
                    #1;
                    check_output("bp_ready", 64'(dma_data_ready_o),   64'h0);
                    check_output("bp_v",     64'(cache_dma_data_v_o), 64'(onehot(id)));
                    check_output("bp_busy",  64'(busy_o),             64'h1);
                    tick();
                end
            end
            cache_dma_data_ready_i = '1;
            dma_data_v_i = 1'b1;
            dma_data_i   = base + DW'(k);
            #1;
            check_output("rd_v",     64'(cache_dma_data_v_o), 64'(onehot(id)));
            check_output("rd_data",  64'(cache_dma_data_o),   64'(base + DW'(k)));
            check_output("rd_ready", 64'(dma_data_ready_o),   64'h1);
            check_output("rd_busy",  64'(busy_o),             64'h1);
            check_output("rd_no_pkt_yumi", 64'(cache_dma_pkt_yumi_o), 64'h0);
            tick();
        end
        dma_data_v_i = 1'b0;
        #1;
        check_output("rd_done_busy", 64'(busy_o), 64'h0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int e, cyc, yumis;
        reset_n = 1'b0;
        cache_dma_pkt_v_i = '1;
        cache_dma_data_ready_i = '1;
        cache_dma_data_v_i = '1;
        dma_pkt_yumi_i = 1'b1;
        dma_data_i = 32'hFFFF_FFFF;
        dma_data_v_i = 1'b1;
        dma_data_yumi_i = 1'b1;
        for (int i = 0; i < N; i++) begin
            pkt_a[i]   = {1'b1, 32'hDEAD_0000};
            evict_a[i] = 32'hEEEE_EEEE;
        end
        tick();
        tick();
        check_all_quiet("rst");

        cache_dma_pkt_v_i = '0;
        cache_dma_data_v_i = '0;
        dma_pkt_yumi_i = 1'b0;
        dma_data_v_i = 1'b0;
        dma_data_yumi_i = 1'b0;
        reset_n = 1'b1;
        tick();

        // Stray read data and evict valid in IDLE are ignored.
        dma_data_v_i = 1'b1;
        cache_dma_data_v_i = '1;
        dma_data_yumi_i = 1'b1;
        #1;
        check_output("idle_rd_ready", 64'(dma_data_ready_o),      64'h0);
        check_output("idle_cdata_v",  64'(cache_dma_data_v_o),    64'h0);
        check_output("idle_wr_v",     64'(dma_data_v_o),          64'h0);
        check_output("idle_ev_yumi",  64'(cache_dma_data_yumi_o), 64'h0);
        dma_data_v_i = 1'b0;
        cache_dma_data_v_i = '0;
        dma_data_yumi_i = 1'b0;
        tick();

        $display("[TB] single read from cache2 with backpressure");
        pkt_a[2] = {1'b0, 32'h0000_1000};
        cache_dma_pkt_v_i[2] = 1'b1;
        apply_stimulus(2, 32'h0000_1000, 32'hA0, 0, -1, 2, -1, 1'b1);

        $display("[TB] single write from cache1");
        pkt_a[1] = {1'b1, 32'h0000_2000};
        cache_dma_pkt_v_i[1] = 1'b1;
        cache_dma_data_v_i[1] = 1'b1;
        evict_a[1] = 32'hB0;
        #1;
        check_output("wr_idle_busy", 64'(busy_o),                64'h0);
        check_output("wr_idle_v",    64'(dma_data_v_o),          64'h0);
        check_output("wr_idle_yumi", 64'(cache_dma_data_yumi_o), 64'h0);
        tick();
        dma_pkt_yumi_i = 1'b1;
        #1;
        check_output("wr_pkt",       64'(dma_pkt_o),            64'h1_0000_2000);
        check_output("wr_pkt_yumi",  64'(cache_dma_pkt_yumi_o), 64'(4'b0010));
        check_output("wr_grant",     64'(grant_id_o),           64'h1);
        tick();
        dma_pkt_yumi_i = 1'b0;
        cache_dma_pkt_v_i[1] = 1'b0;
        e = 0; cyc = 0; yumis = 0;
        while (e < B && cyc < 4*B) begin
            evict_a[1] = 32'hB0 + DW'(e);
            dma_data_yumi_i = (cyc % 2 == 1);
            #1;
            check_output("wr_v",    64'(dma_data_v_o), 64'h1);
            check_output("wr_data", 64'(dma_data_o),   64'(32'hB0 + DW'(e)));
            check_output("wr_cyumi",64'(cache_dma_data_yumi_o), dma_data_yumi_i ? 64'h2 : 64'h0);
            check_output("wr_busy", 64'(busy_o),       64'h1);
            if (cache_dma_data_yumi_o[1]) yumis++;
            if (dma_data_yumi_i) e++;
            tick();
            cyc++;
        end
        dma_data_yumi_i = 1'b0;
        cache_dma_data_v_i[1] = 1'b0;
        #1;
        check_output("wr_done_busy",  64'(busy_o), 64'h0);
        check_output("wr_yumi_count", 64'(yumis),  64'd8);
        check_output("wr_word_count", 64'(e),      64'd8);
        tick();

        $display("[TB] packet stall on cache0 while cache3 requests");
        pkt_a[0] = {1'b0, 32'h0000_3000};
        pkt_a[3] = {1'b0, 32'h0000_4000};
        cache_dma_pkt_v_i[0] = 1'b1;
        apply_stimulus(0, 32'h0000_3000, 32'h30, 10, 3, -1, -1, 1'b1);
        apply_stimulus(3, 32'h0000_4000, 32'h40, 0, -1, -1, -1, 1'b1);
        tick();

        $display("[TB] reset during read after three words");
        pkt_a[1] = {1'b0, 32'h0000_5000};
        cache_dma_pkt_v_i[1] = 1'b1;
        apply_stimulus(1, 32'h0000_5000, 32'hC0, 0, -1, -1, 3, 1'b1);
        reset_n = 1'b0;
        dma_data_v_i = 1'b1;
        dma_data_i = 32'h1234_5678;
        dma_pkt_yumi_i = 1'b1;
        dma_data_yumi_i = 1'b1;
        cache_dma_data_v_i = '1;
        #1;
        check_all_quiet("rst_mid");
        tick();
        tick();
        check_all_quiet("rst_hold");
        dma_data_v_i = 1'b0;
        dma_pkt_yumi_i = 1'b0;
        dma_data_yumi_i = 1'b0;
        cache_dma_data_v_i = '0;
        for (int i = 0; i < N; i++) pkt_a[i] = {1'b0, 32'h100 * i};
        cache_dma_pkt_v_i = '1;
        reset_n = 1'b1;

        $display("[TB] round-robin with all caches requesting");
        for (int r = 0; r < 5; r++) begin
            apply_stimulus(r % N, 32'h100 * (r % N), 32'h10 * r, 0, -1, -1, -1, 1'b0);
        end
        cache_dma_pkt_v_i = '0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
